// File: rtl/rr_mux_arb.sv
// N-to-1 round-robin arbitrated mux with a single registered output slot and valid/ready handshake.
// Define RR_MUX_FIXED_PRIO_EN to replace round-robin with fixed priority (lowest valid index wins).
module rr_mux_arb #(
  parameter int N  = 8,
  parameter int W  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_sel,
  input  logic           out_ready
);

  logic [SW-1:0] scan_base;
  logic [N-1:0]  grant;
  logic [SW-1:0] grant_idx;
  logic          found;
  logic [SW:0]   scan_pos;
  logic [SW-1:0] scan_idx;
  logic          can_load;
  logic          take;

`ifdef RR_MUX_FIXED_PRIO_EN
  assign scan_base = '0;
`else
  logic [SW-1:0] rr_ptr;

  assign scan_base = rr_ptr;

  // Pointer moves past the winner only on a transfer; wrap is explicit so non-power-of-two N works.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (take) begin
      rr_ptr <= (grant_idx == SW'(N - 1)) ? '0 : SW'(grant_idx + 1'b1);
    end
  end
`endif

  // Scan N positions starting at scan_base, first valid channel wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    scan_pos  = '0;
    scan_idx  = '0;
    for (int i = 0; i < N; i++) begin
      scan_pos = {1'b0, scan_base} + (SW + 1)'(i);
      if (scan_pos >= (SW + 1)'(N)) begin
        scan_pos = scan_pos - (SW + 1)'(N);
      end
      scan_idx = scan_pos[SW-1:0];
      if (!found && in_valid[scan_idx]) begin
        found           = 1'b1;
        grant[scan_idx] = 1'b1;
        grant_idx       = scan_idx;
      end
    end
  end

  assign can_load = ~out_valid | out_ready;
  // rst_n gating keeps producers from seeing a ready while the block is held in reset.
  assign in_ready = grant & {N{can_load & rst_n}};
  assign take     = |in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (take) begin
      out_valid <= 1'b1;
      out_data  <= in_data[grant_idx*W +: W];
      out_sel   <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_mux_arb.sv
// Directed testbench for rr_mux_arb: an N=8 instance for most scenarios and an N=5 instance for wrap.
// Round-robin scenarios run in the default build; RR_MUX_FIXED_PRIO_EN selects the fixed-priority scenario.
module tb_rr_mux_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_valid;
  logic [63:0] in_data;
  logic [7:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [2:0]  out_sel;
  logic        out_ready;

  logic [4:0]  v5;
  logic [39:0] d5;
  logic [4:0]  r5;
  logic        ov5;
  logic [7:0]  od5;
  logic [2:0]  os5;
  logic        ordy5;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rr_mux_arb #(.N(8), .W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel), .out_ready(out_ready)
  );

  rr_mux_arb #(.N(5), .W(8)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(v5), .in_data(d5), .in_ready(r5),
    .out_valid(ov5), .out_data(od5), .out_sel(os5), .out_ready(ordy5)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_data();
    for (int k = 0; k < 8; k++) in_data[k*8 +: 8] = 8'h10 + 8'(k);
    for (int k = 0; k < 5; k++) d5[k*8 +: 8] = 8'h20 + 8'(k);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 8'hFF; out_ready = 1'b1; fill_data();
    v5 = '0; ordy5 = 1'b1;
    #2;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", out_data); end
    n_cmp++; if (out_sel !== 3'd0) begin n_err++; $display("FAIL reset_sel: got %0d want 0", out_sel); end
    n_cmp++; if (in_ready !== 8'h00) begin n_err++; $display("FAIL reset_ready: got %h want 00", in_ready); end
    step(); step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_hold_valid: got %b want 0", out_valid); end
    in_valid = 8'h00;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    in_valid = 8'h08; in_data[3*8 +: 8] = 8'hCB; out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 8'h08) begin n_err++; $display("FAIL single_ready: got %h want 08", in_ready); end
    step();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 8'hCB) begin n_err++; $display("FAIL single_data: got %h want cb", out_data); end
    n_cmp++; if (out_sel !== 3'd3) begin n_err++; $display("FAIL single_sel: got %0d want 3", out_sel); end
    // Pointer now 4: with channels 0 and 3 valid, the scan 4,5,6,7,0 reaches channel 0 first.
    in_valid = 8'h09;
    #1;
    n_cmp++; if (in_ready !== 8'h01) begin n_err++; $display("FAIL single_ptr_ready: got %h want 01", in_ready); end
    step();
    n_cmp++; if (out_sel !== 3'd0) begin n_err++; $display("FAIL single_ptr_sel: got %0d want 0", out_sel); end
    in_valid = 8'h00;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 8'h10) begin n_err++; $display("FAIL drain_hold_data: got %h want 10", out_data); end
    step();
    // Idle cycles must not move the pointer (still 1): channels 1 and 3 -> channel 1.
    in_valid = 8'h0A;
    #1;
    n_cmp++; if (in_ready !== 8'h02) begin n_err++; $display("FAIL idle_ptr_ready: got %h want 02", in_ready); end
    in_valid = 8'h00;
    fill_data();
  endtask

  task automatic test_all_valid();
    do_reset();
    fill_data(); in_valid = 8'hFF; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      n_cmp++; if (in_ready !== (8'h01 << (i % 8))) begin n_err++; $display("FAIL rot_ready[%0d]: got %h want %h", i, in_ready, 8'h01 << (i % 8)); end
      step();
      n_cmp++; if (out_valid !== 1'b1 || out_sel !== 3'(i % 8) || out_data !== 8'h10 + 8'(i % 8)) begin
        n_err++; $display("FAIL rot_out[%0d]: got v=%b sel=%0d data=%h want v=1 sel=%0d data=%h", i, out_valid, out_sel, out_data, i % 8, 8'h10 + 8'(i % 8));
      end
    end
    in_valid = 8'h00;
  endtask

  task automatic test_back_to_back();
    in_valid = 8'hFF; out_ready = 1'b1;
    step();
    n_cmp++; if (out_sel !== 3'd0 || out_data !== 8'h10) begin n_err++; $display("FAIL bp_first: got sel=%0d data=%h want sel=0 data=10", out_sel, out_data); end
    out_ready = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 8'h00) begin n_err++; $display("FAIL bp_ready: got %h want 00", in_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (out_valid !== 1'b1 || out_sel !== 3'd0 || out_data !== 8'h10 || in_ready !== 8'h00) begin
        n_err++; $display("FAIL bp_hold[%0d]: got v=%b sel=%0d data=%h rdy=%h want v=1 sel=0 data=10 rdy=00", i, out_valid, out_sel, out_data, in_ready);
      end
    end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 8'h02) begin n_err++; $display("FAIL bp_release_ready: got %h want 02", in_ready); end
    step();
    n_cmp++; if (out_valid !== 1'b1 || out_sel !== 3'd1 || out_data !== 8'h11) begin
      n_err++; $display("FAIL bp_no_bubble: got v=%b sel=%0d data=%h want v=1 sel=1 data=11", out_valid, out_sel, out_data);
    end
    in_valid = 8'h00;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_mid_reset();
    // Pointer is 2; load 0x5A from channel 5 and hold it under backpressure.
    in_data[5*8 +: 8] = 8'h5A; in_valid = 8'h20; out_ready = 1'b0;
    step();
    in_valid = 8'h00;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h5A || out_sel !== 3'd5) begin
      n_err++; $display("FAIL mid_load: got v=%b data=%h sel=%0d want v=1 data=5a sel=5", out_valid, out_data, out_sel);
    end
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 3'd0) begin
      n_err++; $display("FAIL mid_async: got v=%b data=%h sel=%0d want v=0 data=00 sel=0", out_valid, out_data, out_sel);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    fill_data(); in_valid = 8'h44; out_ready = 1'b1;
    step();
    n_cmp++; if (out_sel !== 3'd2 || out_data !== 8'h12) begin
      n_err++; $display("FAIL mid_ptr_reset: got sel=%0d data=%h want sel=2 data=12", out_sel, out_data);
    end
    in_valid = 8'h00;
    step();
  endtask

  task automatic test_wrap();
    in_valid = 8'h40;
    step();
    in_valid = 8'h81;
    #1;
    n_cmp++; if (in_ready !== 8'h80) begin n_err++; $display("FAIL wrap8_ready7: got %h want 80", in_ready); end
    step();
    n_cmp++; if (out_sel !== 3'd7 || out_data !== 8'h17) begin n_err++; $display("FAIL wrap8_sel7: got sel=%0d data=%h want sel=7 data=17", out_sel, out_data); end
    n_cmp++; if (in_ready !== 8'h01) begin n_err++; $display("FAIL wrap8_ready0: got %h want 01", in_ready); end
    step();
    n_cmp++; if (out_sel !== 3'd0 || out_data !== 8'h10) begin n_err++; $display("FAIL wrap8_sel0: got sel=%0d data=%h want sel=0 data=10", out_sel, out_data); end
    in_valid = 8'h00;
    // N=5 instance: channel 3 moves its pointer to 4, then 4 wins and wraps to 0.
    v5 = 5'b01000; ordy5 = 1'b1;
    step();
    n_cmp++; if (ov5 !== 1'b1 || os5 !== 3'd3 || od5 !== 8'h23) begin n_err++; $display("FAIL wrap5_sel3: got v=%b sel=%0d data=%h want v=1 sel=3 data=23", ov5, os5, od5); end
    v5 = 5'b10001;
    #1;
    n_cmp++; if (r5 !== 5'b10000) begin n_err++; $display("FAIL wrap5_ready4: got %b want 10000", r5); end
    step();
    n_cmp++; if (os5 !== 3'd4 || od5 !== 8'h24) begin n_err++; $display("FAIL wrap5_sel4: got sel=%0d data=%h want sel=4 data=24", os5, od5); end
    step();
    n_cmp++; if (os5 !== 3'd0 || od5 !== 8'h20) begin n_err++; $display("FAIL wrap5_sel0: got sel=%0d data=%h want sel=0 data=20", os5, od5); end
    v5 = '0;
    step();
    n_cmp++; if (ov5 !== 1'b0) begin n_err++; $display("FAIL wrap5_drain: got %b want 0", ov5); end
  endtask

  task automatic test_fixed_prio();
    do_reset();
    fill_data(); in_valid = 8'hFF; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      n_cmp++; if (out_sel !== 3'd0 || out_data !== 8'h10) begin n_err++; $display("FAIL fixed_sel[%0d]: got sel=%0d want 0", i, out_sel); end
    end
    in_valid = 8'h81;
    #1;
    n_cmp++; if (in_ready !== 8'h01) begin n_err++; $display("FAIL fixed_ready: got %h want 01", in_ready); end
    in_valid = 8'h80;
    #1;
    n_cmp++; if (in_ready !== 8'h80) begin n_err++; $display("FAIL fixed_ready7: got %h want 80", in_ready); end
    in_valid = 8'h00;
  endtask

  initial begin
    in_valid = '0; in_data = '0; out_ready = 1'b0; v5 = '0; d5 = '0; ordy5 = 1'b0; rst_n = 1'b0;
    test_reset();
`ifdef RR_MUX_FIXED_PRIO_EN
    test_fixed_prio();
`else
    test_single();
    test_all_valid();
    test_back_to_back();
    test_mid_reset();
    test_wrap();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rr_mux_arb.md
Name: rr_mux_arb

Overview:
- Parametrised N-to-1 multiplexer with registered output and a valid/ready handshake on every channel.
- Selection comes from an internal round-robin arbiter instead of an external select bus.
- Sits where several producers share one consumer: it picks one valid channel per cycle and forwards its data plus the winning index.
- Successor to the fixed 8:1 gate-level mux: generalised in channel count and data width, with flow control and fairness added.

Parameters:
- N, 8, number of input channels (N >= 2; need not be a power of two).
- W, 8, data width per channel.
- SW, $clog2(N), width of the select/index fields (derived; not to be overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  N  per-channel request; bit k belongs to channel k.
- in_data  input  N*W  packed channel data; channel k occupies bits [k*W +: W].
- in_ready  output  N  per-channel accept; one-hot or zero.
- out_valid  output  1  output register holds a word.
- out_data  output  W  forwarded data.
- out_sel  output  SW  index of the channel that supplied out_data.
- out_ready  input  1  consumer accept.

Behaviour:
- Reset (async assert, sync-released by the environment):
  - out_valid=0, out_data=0, out_sel=0, rr_ptr=0.
  - All in_ready=0 while rst_n=0.
- Slot free: can_load = ~out_valid | out_ready.
- Grant (combinational):
  - Scan channels starting at index rr_ptr, ascending, wrapping N-1 -> 0.
  - The first channel with in_valid=1 wins: grant is one-hot, or zero if none is valid.
- Ready: in_ready = grant & {N{can_load}}. Ready depends on in_valid; producers must not make in_valid depend on in_ready.
- Transfer: channel k transfers when in_valid[k] & in_ready[k].
- On a transfer (registered at the rising edge):
  - out_data <= in_data[k], out_sel <= k, out_valid <= 1.
  - rr_ptr <= (k == N-1) ? 0 : k+1. Wrap is explicit; no modulo on non-power-of-two N.
- No transfer while out_ready=1 and out_valid=1: out_valid <= 0; out_data and out_sel hold their last value.
- No transfer while out_valid=1 and out_ready=0: all outputs hold. in_ready is all zero, so no producer is lost.
- Simultaneous drain and load: with out_valid=1, out_ready=1 and a new grant, the new word replaces the old in the same edge. Sustained throughput is one word per cycle.
- Latency: one cycle from input acceptance to out_valid.
- rr_ptr changes only on a transfer. Idle cycles do not move it.
- Fairness: with all N channels continuously valid and out_ready=1, grants rotate 0,1,...,N-1,0,... Each channel waits at most N-1 grants.
- Data stability: once out_valid=1 and out_ready=0, out_data and out_sel are stable until accepted.
- Reset mid-operation: the held word is discarded, out_valid drops immediately (asynchronously) and rr_ptr returns to 0.
- No internal buffering beyond the single output register.

Optional Feature:
- Macro: RR_MUX_FIXED_PRIO_EN.
- Defined:
  - Arbitration is fixed priority; the lowest valid index always wins.
  - rr_ptr is not implemented.
  - All other handshake rules are unchanged.
- Undefined (default): round-robin as described above.

Test Plan:
- Reset mid-stream: N=8, W=8, out_valid=1 holding 0x5A, assert rst_n=0 -> out_valid=0, out_data=0x00 and out_sel=0 without waiting for clk; after release, first grant goes to the lowest valid channel at or above index 0.
- Single channel: only in_valid[3]=1 with data 0xCB, out_ready=1 -> next cycle out_valid=1, out_data=0xCB, out_sel=3; rr_ptr=4.
- All channels valid with distinct data 0x10..0x17, out_ready=1 for 16 cycles -> out_sel sequence 0..7,0..7; one word per cycle; in_ready one-hot every cycle.
- Backpressure: out_ready=0 after the first word -> out_data and out_sel frozen; in_ready=0 for all channels; releasing out_ready -> the next grant loads in the same edge as the drain, with no bubble.
- Wrap: rr_ptr=7, in_valid=8'b1000_0001 -> channel 7 wins, then channel 0; repeat with N=5 and check index 4 wraps to 0.
- Fixed-priority build (RR_MUX_FIXED_PRIO_EN): in_valid=8'hFF held -> out_sel=0 on every transfer; channel 7 is never granted while channel 0 is valid.
